branch_target_buffer: RTL
=========================

// Module: branch_target_buffer
// PURPOSE
// - Fetch-stage next-PC generator. Sits directly downstream of the direction predictor:
//   consumes its taken prediction (pcsrcPF) and supplies npcF to the PC register.
// - 2-way set-associative BTB caches taken-branch targets; written at M-stage resolution.
// - Mispredict redirect (pmis/fpcM) overrides every other next-PC source.
// PARAMETERS
// - INDEX_W  4  set index bits; SETS = 1<<INDEX_W, 2 ways per set
// - TAG_W    8  stored tag bits
// PORTS
// - clk            in   1   clock
// - rst            in   1   reset: synchronous, active-high
// - pcF            in   32  current fetch PC
// - stallF         in   1   hold PC
// - pcsrcPF        in   1   direction prediction for pcF (1 = taken)
// - branchM        in   1   M-stage instruction is a branch
// - pcM            in   32  M-stage branch PC
// - pcsrcM         in   1   resolved direction (1 = taken)
// - targetM        in   32  resolved branch target
// - pmis           in   1   mispredict at M
// - fpcM           in   32  correct redirect PC
// - hitF           out  1   BTB tag hit for pcF
// - btb_targetF    out  32  stored target; 0 on miss
// - predtakenF     out  1   pcsrcPF & hitF; pipeline carries this as the prediction
// - npcF           out  32  next fetch PC
// BEHAVIOUR
// - Addressing:
//   - idx = pc[INDEX_W+1:2].
//   - tag = pc[INDEX_W+TAG_W+1:INDEX_W+2].
//   - Applies to both pcF and pcM.
// - Storage per set and way: valid, tag, target[31:0]. Plus one lru bit per set
//   (lru = way to evict next).
// - Reset: all valid = 0, all lru = 0, targets/tags = 0.
//   - With rst high, lookups miss, so hitF = 0, predtakenF = 0, btb_targetF = 0.
//   - npcF follows the priority rules below.
// - Lookup (F):
//   - Purely combinational, 0-cycle latency.
//   - hitF = valid & tag match in either way.
//   - Both ways matching cannot occur; if it does, way0 wins.
// - npcF priority:
//   1. pmis -> fpcM.
//   2. stallF -> pcF.
//   3. pcsrcPF & hitF -> btb_targetF.
//   4. Otherwise pcF + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
// - Predicted taken but BTB miss: fall through to pcF+4; predtakenF = 0.
// - Update (posedge clk, when branchM & pcsrcM & !rst):
//   - Tag hit in way w: target[w] <= targetM; lru <= ~w.
//   - Miss with an invalid way: allocate the lowest invalid way; valid = 1, write
//     tag/target; lru <= ~w.
//   - Miss, both ways valid: replace way lru; lru <= ~lru.
// - branchM & !pcsrcM (not taken): no state change; existing entries are kept.
// - Update is independent of pmis and stallF.
// - Same-cycle read/write to the same set: lookup returns pre-write contents.
//   No bypass; the new entry is visible from the next cycle.
// - rst asserted mid-operation: the update in that cycle is discarded.
// - Lookups do not touch lru.
// TESTING
// - Reset, then pcF=0x00400010, pcsrcPF=1 -> hitF=0, predtakenF=0, npcF=0x00400014.
// - Write branchM=1, pcsrcM=1, pcM=0x00400010, targetM=0x00400100.
//   Next cycle pcF=0x00400010, pcsrcPF=1 -> hitF=1, npcF=0x00400100.
//   Same lookup with pcsrcPF=0 -> npcF=0x00400014.
// - Taken writes to PCs 0x00400010, 0x00401010, 0x00402010 (same idx, different tags).
//   -> 0x00400010 evicted; 0x00401010 and 0x00402010 still hit.
// - pmis=1, fpcM=0x00400200, stallF=1, with a BTB hit -> npcF=0x00400200.
//   Same with pmis=0 -> npcF=pcF.
// - Not-taken update at pcM=0x00400030 -> later lookup misses.
//   Same-cycle write and lookup of 0x00400040 -> miss that cycle, hit the next.
// - Fill entries, pulse rst for 1 cycle -> all lookups miss; pcF=0xFFFFFFFC -> npcF=0.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// ---------------------------------------------------------------------------
// branch_target_buffer_if
// Bundles the fetch-stage lookup signals and the M-stage resolution signals
// used by the branch target buffer.
//   master : pipeline side, drives pcF/stallF/pcsrcPF, the M-stage update
//            (branchM/pcM/pcsrcM/targetM) and the redirect (pmis/fpcM);
//            observes hitF/btb_targetF/predtakenF/npcF
//   slave  : BTB side, the mirror image of master
// ---------------------------------------------------------------------------
interface branch_target_buffer_if;
  logic [31:0] pcF;
  logic        stallF;
  logic        pcsrcPF;
  logic        branchM;
  logic [31:0] pcM;
  logic        pcsrcM;
  logic [31:0] targetM;
  logic        pmis;
  logic [31:0] fpcM;
  logic        hitF;
  logic [31:0] btb_targetF;
  logic        predtakenF;
  logic [31:0] npcF;

  modport master (
    output pcF, stallF, pcsrcPF, branchM, pcM, pcsrcM, targetM, pmis, fpcM,
    input  hitF, btb_targetF, predtakenF, npcF
  );

  modport slave (
    input  pcF, stallF, pcsrcPF, branchM, pcM, pcsrcM, targetM, pmis, fpcM,
    output hitF, btb_targetF, predtakenF, npcF
  );
endinterface

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
// Fetch-stage next-PC generator with a 2-way set-associative branch target
// buffer. Lookups are combinational on pcF; taken branches resolved in M are
// written into the buffer on the clock edge. A mispredict redirect overrides
// every other next-PC source.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset (clears all valid and lru bits)
//   bus  : branch_target_buffer_if.slave
//          in  pcF, stallF, pcsrcPF        fetch PC, stall, direction guess
//          in  branchM, pcM, pcsrcM, targetM  M-stage branch resolution
//          in  pmis, fpcM                  mispredict redirect
//          out hitF, btb_targetF, predtakenF, npcF
// ---------------------------------------------------------------------------
module branch_target_buffer #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_target_buffer_if.slave   bus
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]  valid0;
  logic [SETS-1:0]  valid1;
  logic [SETS-1:0]  lru;
  logic [TAG_W-1:0] tag0 [SETS];
  logic [TAG_W-1:0] tag1 [SETS];
  logic [31:0]      tgt0 [SETS];
  logic [31:0]      tgt1 [SETS];

  logic [INDEX_W-1:0] idxF;
  logic [TAG_W-1:0]   tagF;
  logic               hitWay0F;
  logic               hitWay1F;

  logic [INDEX_W-1:0] idxM;
  logic [TAG_W-1:0]   tagM;
  logic               updEn;
  logic               updHit0;
  logic               updHit1;
  logic               updWay;

  // Upper and byte-offset bits of pcM never take part in indexing or tagging.
  logic unusedPcM;
  assign unusedPcM = &{1'b0, bus.pcM[31:INDEX_W+TAG_W+2], bus.pcM[1:0]};

  // Fetch lookup. Hits are masked while rst is high so the reset cycle itself
  // already reports a miss, before the arrays have actually been cleared.
  // If both ways ever matched, way0 takes priority.
  always_comb begin
    idxF     = bus.pcF[INDEX_W+1:2];
    tagF     = bus.pcF[INDEX_W+TAG_W+1:INDEX_W+2];
    hitWay0F = !rst && valid0[idxF] && (tag0[idxF] == tagF);
    hitWay1F = !rst && valid1[idxF] && (tag1[idxF] == tagF);

    bus.hitF        = hitWay0F || hitWay1F;
    bus.btb_targetF = 32'h0;
    if (hitWay0F) begin
      bus.btb_targetF = tgt0[idxF];
    end else if (hitWay1F) begin
      bus.btb_targetF = tgt1[idxF];
    end
    bus.predtakenF = bus.pcsrcPF && bus.hitF;

    // Redirect beats stall, stall beats prediction, prediction beats pc+4.
    if (bus.pmis) begin
      bus.npcF = bus.fpcM;
    end else if (bus.stallF) begin
      bus.npcF = bus.pcF;
    end else if (bus.predtakenF) begin
      bus.npcF = bus.btb_targetF;
    end else begin
      bus.npcF = bus.pcF + 32'd4;
    end
  end

  // Way selection for the M-stage write: refresh a matching way, otherwise
  // fill the lowest empty way, otherwise evict the way named by lru.
  always_comb begin
    idxM    = bus.pcM[INDEX_W+1:2];
    tagM    = bus.pcM[INDEX_W+TAG_W+1:INDEX_W+2];
    updEn   = bus.branchM && bus.pcsrcM;
    updHit0 = valid0[idxM] && (tag0[idxM] == tagM);
    updHit1 = valid1[idxM] && (tag1[idxM] == tagM);

    if (updHit0) begin
      updWay = 1'b0;
    end else if (updHit1) begin
      updWay = 1'b1;
    end else if (!valid0[idxM]) begin
      updWay = 1'b0;
    end else if (!valid1[idxM]) begin
      updWay = 1'b1;
    end else begin
      updWay = lru[idxM];
    end
  end

  // Storage update. Every write case leaves lru pointing at the way that was
  // not just written, so one assignment covers hit, fill and eviction.
  // Writing the tag again on a hit is harmless since it is unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag0[i] <= '0;
        tag1[i] <= '0;
        tgt0[i] <= '0;
        tgt1[i] <= '0;
      end
    end else if (updEn) begin
      if (!updWay) begin
        valid0[idxM] <= 1'b1;
        tag0[idxM]   <= tagM;
        tgt0[idxM]   <= bus.targetM;
      end else begin
        valid1[idxM] <= 1'b1;
        tag1[idxM]   <= tagM;
        tgt1[idxM]   <= bus.targetM;
      end
      lru[idxM] <= ~updWay;
    end
  end

endmodule
